// File: rtl/led_cmd_if.sv
// led_cmd_if: valid/ready command channel carrying per-LED pattern requests
interface led_cmd_if;
  logic       valid;
  logic       ready;
  logic       led;
  logic [1:0] mode;
  logic [3:0] arg;
  modport master (output valid, led, mode, arg, input ready);
  modport slave (input valid, led, mode, arg, output ready);
endinterface

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: green/red LED pattern driver (OFF/ON/BLINK/CODE) with optional LED_PWM_EN dimming
module led_status_ctrl #(
  parameter int CLK_HZ = 48000000,
  parameter int TICK_HZ = 1000,
  parameter int BLINK_UNIT = 50,
  parameter int PULSE_TICKS = 200,
  parameter int GAP_TICKS = 1000,
  parameter int PWM_DUTY = 8
) (
  input  logic       i_ifclk,
  input  logic       i_rst_n,
  led_cmd_if.slave   cmd,
  output logic       o_led_green,
  output logic       o_led_red
);
  localparam int TC = CLK_HZ / TICK_HZ - 1;
  localparam int PW = $clog2(TC + 1);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} code_st_t;
  logic [PW-1:0] pre_q, pre_d;
  logic          rdy_q, rdy_d;
  logic [1:0]    mode_q [2], mode_d [2];
  logic [3:0]    arg_q [2], arg_d [2], pls_q [2], pls_d [2];
  logic [15:0]   cnt_q [2], cnt_d [2];
  logic          ph_q [2], ph_d [2];
  code_st_t      st_q [2], st_d [2];
  logic [1:0]    led_q, led_d;
  logic          tick, acc, lit, done, lit_lvl;
  logic [31:0]   nxt, lim;
`ifdef LED_PWM_EN
  logic [3:0]    slot_q, slot_d;
`endif
  assign cmd.ready = rdy_q;
  assign o_led_green = led_q[0];
  assign o_led_red = led_q[1];
  // next-state: prescaler, handshake, per-LED pattern sequencing and registered pin level
  always_comb begin
    acc = cmd.valid & rdy_q;
    tick = pre_q == PW'(TC);
    pre_d = tick ? '0 : pre_q + 1'b1;
    rdy_d = ~acc;
`ifdef LED_PWM_EN
    slot_d = slot_q + 4'd1;
    lit_lvl = 5'(slot_q) >= 5'(PWM_DUTY);
`else
    lit_lvl = 1'b0;
`endif
    led_d = led_q;
    for (int i = 0; i < 2; i++) begin
      mode_d[i] = mode_q[i];
      arg_d[i] = arg_q[i];
      pls_d[i] = pls_q[i];
      cnt_d[i] = cnt_q[i];
      ph_d[i] = ph_q[i];
      st_d[i] = st_q[i];
      nxt = 32'(cnt_q[i]) + 32'd1;
      lim = mode_q[i] == 2'd2 ? (32'(arg_q[i]) + 32'd1) * 32'(BLINK_UNIT) :
            st_q[i] == S_GAP ? 32'(GAP_TICKS) : 32'(PULSE_TICKS);
      done = nxt >= lim;
      lit = mode_q[i] == 2'd1 || (mode_q[i] == 2'd2 && ph_q[i]) || st_q[i] == S_ON;
      led_d[i] = lit ? lit_lvl : 1'b1;
      if (acc && cmd.led == 1'(i)) begin
        mode_d[i] = cmd.mode;
        arg_d[i] = cmd.arg;
        pls_d[i] = cmd.arg;
        cnt_d[i] = '0;
        ph_d[i] = 1'b1;
        st_d[i] = cmd.mode == 2'd3 && cmd.arg != 4'd0 ? S_ON : S_IDLE;
      end else if (tick && (mode_q[i] == 2'd2 || st_q[i] != S_IDLE)) begin
        cnt_d[i] = done ? '0 : (&cnt_q[i] ? cnt_q[i] : nxt[15:0]);
        if (done) begin
          ph_d[i] = ~ph_q[i];
          st_d[i] = st_q[i] == S_ON ? S_OFF :
                    st_q[i] == S_OFF && pls_q[i] == 4'd0 ? S_GAP :
                    st_q[i] == S_IDLE ? S_IDLE : S_ON;
          pls_d[i] = st_q[i] == S_ON ? pls_q[i] - 4'd1 :
                     st_q[i] == S_GAP ? arg_q[i] : pls_q[i];
        end
      end
    end
  end
  // state registers; reset darkens both LEDs and holds off the handshake
  always_ff @(posedge i_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q <= '0;
      rdy_q <= 1'b0;
      led_q <= 2'b11;
`ifdef LED_PWM_EN
      slot_q <= '0;
`endif
      for (int i = 0; i < 2; i++) begin
        mode_q[i] <= '0;
        arg_q[i] <= '0;
        pls_q[i] <= '0;
        cnt_q[i] <= '0;
        ph_q[i] <= 1'b0;
        st_q[i] <= S_IDLE;
      end
    end else begin
      pre_q <= pre_d;
      rdy_q <= rdy_d;
      led_q <= led_d;
`ifdef LED_PWM_EN
      slot_q <= slot_d;
`endif
      for (int i = 0; i < 2; i++) begin
        mode_q[i] <= mode_d[i];
        arg_q[i] <= arg_d[i];
        pls_q[i] <= pls_d[i];
        cnt_q[i] <= cnt_d[i];
        ph_q[i] <= ph_d[i];
        st_q[i] <= st_d[i];
      end
    end
  end
endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: scoreboard bench with a tick-count reference model of the LED patterns
module tb_led_status_ctrl;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, BU = 2, PT = 3, GT = 5, PD = 4;
  localparam int TC = CLK_HZ / TICK_HZ - 1;
  logic clk = 1'b0, rst_n = 1'b0, g, r;
  led_cmd_if cif();
  led_status_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .BLINK_UNIT(BU), .PULSE_TICKS(PT),
    .GAP_TICKS(GT), .PWM_DUTY(PD)) dut (.i_ifclk(clk), .i_rst_n(rst_n), .cmd(cif),
    .o_led_green(g), .o_led_red(r));
  always #5 clk = ~clk;
  typedef struct packed {logic g; logic r; logic rdy;} exp_t;
  exp_t q[$];
  exp_t e_mdl, e_mon;
  int n_cmp = 0, n_bad = 0;
  int md[2], ag[2], k[2], pre_m = 0, slot_m = 0;
  bit rdy_m = 0, tk, acc;
  task automatic chk(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask
  // lit/dark from mode, arg and the number of ticks counted since the command
  function automatic bit lit_of(int m, int a, int kk);
    int per;
    if (m == 1) return 1;
    if (m == 2) return ((kk / ((a + 1) * BU)) % 2) == 0;
    if (m == 3 && a != 0) begin
      per = 2 * a * PT + GT;
      kk = kk % per;
      return kk < 2 * a * PT && (kk % (2 * PT)) < PT;
    end
    return 0;
  endfunction
  function automatic logic pin_of(int i);
`ifdef LED_PWM_EN
    return lit_of(md[i], ag[i], k[i]) ? logic'(slot_m >= PD) : 1'b1;
`else
    return lit_of(md[i], ag[i], k[i]) ? 1'b0 : 1'b1;
`endif
  endfunction
  // reference model: predicts the pins and ready visible after each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      pre_m = 0; slot_m = 0; rdy_m = 0;
      for (int i = 0; i < 2; i++) begin md[i] = 0; ag[i] = 0; k[i] = 0; end
    end else begin
      e_mdl.g = pin_of(0);
      e_mdl.r = pin_of(1);
      tk = pre_m == TC;
      pre_m = tk ? 0 : pre_m + 1;
      slot_m = (slot_m + 1) % 16;
      acc = cif.valid && rdy_m;
      for (int i = 0; i < 2; i++)
        if (acc && int'(cif.led) == i) begin md[i] = int'(cif.mode); ag[i] = int'(cif.arg); k[i] = 0; end
        else if (tk) k[i]++;
      rdy_m = !acc;
      e_mdl.rdy = rdy_m;
      q.push_back(e_mdl);
    end
  end
  // monitor: compares every cycle on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_green", g, 1'b1);
      chk("rst_red", r, 1'b1);
      chk("rst_ready", cif.ready, 1'b0);
    end else if (q.size() != 0) begin
      e_mon = q.pop_front();
      chk("green", g, e_mon.g);
      chk("red", r, e_mon.r);
      chk("ready", cif.ready, e_mon.rdy);
    end
  end
  task automatic send(logic led, logic [1:0] mode, logic [3:0] arg);
    int n = 0;
    while (!cif.ready && n < 20) begin @(negedge clk); n++; end
    chk("send_ready", cif.ready, 1'b1);
    cif.valid = 1'b1; cif.led = led; cif.mode = mode; cif.arg = arg;
    @(negedge clk);
    cif.valid = 1'b0;
  endtask
  initial begin
    cif.valid = 1'b1; cif.led = 1'b0; cif.mode = 2'd1; cif.arg = 4'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cif.valid = 1'b0;
    send(1'b0, 2'd1, 4'd0); repeat (20) @(negedge clk);
    send(1'b0, 2'd0, 4'd0); repeat (20) @(negedge clk);
    send(1'b1, 2'd2, 4'd1); repeat (200) @(negedge clk);
    send(1'b0, 2'd3, 4'd3); repeat (600) @(negedge clk);
    send(1'b0, 2'd3, 4'd0); repeat (50) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      cif.valid = 1'b1; cif.led = 1'(c % 2);
      cif.mode = c == 0 ? 2'd2 : c == 1 ? 2'd1 : c == 2 ? 2'd3 : 2'd0;
      cif.arg = c == 2 ? 4'd1 : 4'd0;
      @(negedge clk);
    end
    cif.valid = 1'b0;
    repeat (100) @(negedge clk);
    send(1'b1, 2'd3, 4'd2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_green", g, 1'b1);
    chk("async_rst_red", r, 1'b1);
    chk("async_rst_ready", cif.ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    repeat (300) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
